// File: rtl/pen_locator_pkg.sv
// pen_locator_pkg: shared definitions for the light-pen locator.
// Provides the FSM state encodings, the coordinate type, the probe bundle
// carried through the sensor-latency delay line, and the pixel on/off values.
package pen_locator_pkg;

   localparam int COORD_W = 3;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [2:0]         cnt_t;
   typedef logic [1:0]         state_t;

   // FSM state encodings
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_SEEK    = 2'd1;
   localparam state_t ST_CONFIRM = 2'd2;
   localparam state_t ST_LOCKED  = 2'd3;

   // Frame RAM pixel values
   localparam logic PIX_ON  = 1'b1;
   localparam logic PIX_OFF = 1'b0;

   // One probe sample: which pixel (if any) led_driver lit this cycle
   typedef struct packed {
      logic   valid;
      coord_t row;
      coord_t col;
   } probe_t;

endpackage

// File: rtl/pen_locator_if.sv
// pen_locator_if: write stream from pen_locator into led_driver's frame RAM.
//   wr_valid  master->slave  write request pending
//   wr_ready  slave->master  RAM port accepts write
//   wr_row    master->slave  write row
//   wr_col    master->slave  write column
//   wr_data   master->slave  pixel value to write
// Handshake: a transfer happens on every rising clk edge where wr_valid and
// wr_ready are both 1. Once wr_valid is raised, wr_valid/wr_row/wr_col/wr_data
// hold steady until that transfer; wr_ready may change freely at any time and
// the master never waits for wr_ready before raising wr_valid.
interface pen_locator_if;
   import pen_locator_pkg::*;

   logic   wr_valid;
   logic   wr_ready;
   coord_t wr_row;
   coord_t wr_col;
   logic   wr_data;

   modport master (output wr_valid, output wr_row, output wr_col, output wr_data,
                   input  wr_ready);
   modport slave  (input  wr_valid, input  wr_row, input  wr_col, input  wr_data,
                   output wr_ready);
endinterface

// File: rtl/pen_delay_line.sv
// pen_delay_line: DLY-stage shift register for the probe bundle
// {valid,row,col}, lining up the lit pixel with the pen sensor response.
//   clk      system clock
//   rst      synchronous reset, active-high (clears every stage)
//   probe_i  probe sample from led_driver
//   probe_o  probe sample from DLY cycles ago (DLY=0: probe_i unchanged)
module pen_delay_line
   import pen_locator_pkg::*;
#(
   parameter int DLY = 2
) (
   input  logic   clk,
   input  logic   rst,
   input  probe_t probe_i,
   output probe_t probe_o
);

   if (DLY == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign probe_o        = probe_i;
   end else begin : g_shift
      probe_t stage_q [DLY];

      // Shifts every cycle, independent of drawing enable
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < DLY; i++) stage_q[i] <= '0;
         end else begin
            stage_q[0] <= probe_i;
            for (int i = 1; i < DLY; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign probe_o = stage_q[DLY-1];
   end

endmodule

// File: rtl/pen_locator.sv
// pen_locator: turns the debounced light-pen pulse into a confirmed pixel
// and issues one frame-RAM write each time a pixel becomes confirmed.
//   clk, rst        clock, synchronous active-high reset
//   en              drawing enabled
//   erase           1: write 0 (erase), 0: write 1 (draw)
//   frame_start     one-cycle pulse at the start of each probe sweep
//   pix_valid/row/col  probe pixel lit this cycle
//   pen             debounced pen signal, active-high
//   wr_if           write stream to led_driver (master side)
//   pen_on          1 while LOCKED
//   pos_row/pos_col last confirmed pixel
//   overflow        sticky: a confirmed write was dropped while the port was busy
//   dbg_state/dbg_cnt  FSM state and consecutive-frame count
module pen_locator
   import pen_locator_pkg::*;
#(
   parameter int DLY     = 2,
   parameter int CONFIRM = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          erase,
   input  logic          frame_start,
   input  logic          pix_valid,
   input  coord_t        pix_row,
   input  coord_t        pix_col,
   input  logic          pen,
   pen_locator_if.master wr_if,
   output logic          pen_on,
   output coord_t        pos_row,
   output coord_t        pos_col,
   output logic          overflow,
   output state_t        dbg_state,
   output cnt_t          dbg_cnt
);

   localparam cnt_t CNT_MAX = cnt_t'(CONFIRM);

   probe_t probe_in, probe_d;
   logic   pen_q, hit, issue;
   cnt_t   cnt_q, cnt_d;
   logic   seen_q, seen_d;
   coord_t cand_row_q, cand_row_d, cand_col_q, cand_col_d;
   coord_t last_row_q, last_row_d, last_col_q, last_col_d;
   state_t state_q, state_d;
   logic   wr_valid_q, wr_data_q, overflow_q;
   coord_t wr_row_q, wr_col_q, pos_row_q, pos_col_q;

   assign probe_in = '{valid: pix_valid, row: pix_row, col: pix_col};

   pen_delay_line #(.DLY(DLY)) u_delay (
      .clk     (clk),
      .rst     (rst),
      .probe_i (probe_in),
      .probe_o (probe_d)
   );

   // Rising pen edge aligned with the pixel that was lit DLY cycles ago
   assign hit = en & pen & ~pen_q & probe_d.valid;

   always_comb begin
      cnt_d      = cnt_q;
      seen_d     = seen_q;
      cand_row_d = cand_row_q;
      cand_col_d = cand_col_q;
      last_row_d = last_row_q;
      last_col_d = last_col_q;
      issue      = 1'b0;
      if (!en) begin
         cnt_d      = '0;
         seen_d     = 1'b0;
         last_row_d = '0;
         last_col_d = '0;
      end else begin
         if (frame_start) begin
            if (seen_q) begin
               if (cand_row_q == last_row_q && cand_col_q == last_col_q) begin
                  if (cnt_q < CNT_MAX) cnt_d = cnt_q + 3'd1;
               end else begin
                  last_row_d = cand_row_q;
                  last_col_d = cand_col_q;
                  cnt_d      = 3'd1;
               end
               // Write only when the count arrives at CONFIRM, not while it
               // sits there; a new pixel with CONFIRM=1 also counts as arrival.
               issue = (cnt_d == CNT_MAX) &&
                       ((cnt_q != CNT_MAX) || (last_row_d != last_row_q) ||
                        (last_col_d != last_col_q));
            end else begin
               cnt_d = '0;
            end
            seen_d = 1'b0;
         end
         // A hit on the frame_start cycle opens the new frame's capture
         if (hit && !seen_d) begin
            seen_d     = 1'b1;
            cand_row_d = probe_d.row;
            cand_col_d = probe_d.col;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_SEEK;
            default: begin
               if (cnt_d == '0)          state_d = ST_SEEK;
               else if (cnt_d >= CNT_MAX) state_d = ST_LOCKED;
               else                      state_d = ST_CONFIRM;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pen_q      <= 1'b0;
         cnt_q      <= '0;
         seen_q     <= 1'b0;
         cand_row_q <= '0;
         cand_col_q <= '0;
         last_row_q <= '0;
         last_col_q <= '0;
         state_q    <= ST_IDLE;
         wr_valid_q <= 1'b0;
         wr_row_q   <= '0;
         wr_col_q   <= '0;
         wr_data_q  <= PIX_OFF;
         pos_row_q  <= '0;
         pos_col_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         pen_q      <= pen;
         cnt_q      <= cnt_d;
         seen_q     <= seen_d;
         cand_row_q <= cand_row_d;
         cand_col_q <= cand_col_d;
         last_row_q <= last_row_d;
         last_col_q <= last_col_d;
         state_q    <= state_d;
         if (issue) begin
            // Position tracks the pen even when the RAM write must be dropped
            pos_row_q <= last_row_d;
            pos_col_q <= last_col_d;
            if (wr_valid_q && !wr_if.wr_ready) begin
               overflow_q <= 1'b1;
            end else begin
               wr_valid_q <= 1'b1;
               wr_row_q   <= last_row_d;
               wr_col_q   <= last_col_d;
               wr_data_q  <= erase ? PIX_OFF : PIX_ON;
            end
         end else if (wr_valid_q && wr_if.wr_ready) begin
            wr_valid_q <= 1'b0;
         end
      end
   end

   assign wr_if.wr_valid = wr_valid_q;
   assign wr_if.wr_row   = wr_row_q;
   assign wr_if.wr_col   = wr_col_q;
   assign wr_if.wr_data  = wr_data_q;
   assign pen_on         = (state_q == ST_LOCKED);
   assign pos_row        = pos_row_q;
   assign pos_col        = pos_col_q;
   assign overflow       = overflow_q;
   assign dbg_state      = state_q;
   assign dbg_cnt        = cnt_q;

endmodule

// File: doc/pen_locator.md
Name: pen_locator

Overview:
- Converts the debounced light-pen pulse into a confirmed pixel coordinate and issues write requests to the 8x8 frame RAM.
- Sits between the pen debouncer and led_driver. It consumes led_driver's per-pixel probe strobe and the debounced pen signal.
- It produces a valid/ready write stream into the RAM write port of led_driver. It also drives the pen position to seg_driver.
- Compensates fixed sensor latency and requires the same pixel to be hit on CONFIRM consecutive frames before writing.

Parameters:
- DLY, 2: cycles from pixel lit to pen response (0..7). Probe coordinates are delayed by this many cycles.
- CONFIRM, 2: consecutive frames hitting the same pixel required before a write (1..7).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  drawing enabled (decoded from st state/state_deep)
- erase  in  1  1: write data 0 (erase); 0: write data 1 (draw)
- frame_start  in  1  one-cycle pulse at start of each probe sweep (from led_driver)
- pix_valid  in  1  a single probe pixel is lit this cycle
- pix_row  in  3  row of lit probe pixel
- pix_col  in  3  column of lit probe pixel
- pen  in  1  debounced pen signal, active-high
- wr_valid  out  1  write request pending
- wr_ready  in  1  RAM port accepts write
- wr_row  out  3  write row
- wr_col  out  3  write column
- wr_data  out  1  pixel value to write
- pen_on  out  1  1 while in LOCKED state
- pos_row  out  3  last confirmed row
- pos_col  out  3  last confirmed column
- overflow  out  1  sticky: a confirmed write was dropped because the output was busy

Behaviour:
- Reset: all outputs 0, state IDLE. Delay line, counters, candidate and last registers all cleared.
- Delay line:
  - DLY-stage shift register of {pix_valid, pix_row, pix_col}, giving d_valid/d_row/d_col.
  - DLY=0 passes the inputs straight through.
  - The delay line shifts every cycle regardless of en.
- Hit: hit = en & pen & ~pen_q & d_valid, where pen_q is pen registered one cycle (rising edge).
- Per-frame capture:
  - The first hit in a frame latches cand_row/cand_col and sets hit_seen.
  - Later hits in the same frame are ignored.
- Frame evaluation on frame_start (uses hit_seen from before this cycle):
  - hit_seen=1, cand equal to last, cnt<CONFIRM: cnt++.
  - hit_seen=1, cand differs from last: last<=cand, cnt<=1.
  - hit_seen=0: cnt<=0.
  - hit_seen is then cleared. A hit in the same cycle as frame_start belongs to the new frame: it sets hit_seen after the clear.
- States:
  - IDLE (en=0) -> SEEK when en=1.
  - SEEK (cnt=0) -> CONFIRM when cnt becomes 1.
  - CONFIRM -> LOCKED when cnt reaches CONFIRM. CONFIRM=1 goes SEEK->LOCKED directly.
  - CONFIRM or LOCKED -> SEEK when cnt is cleared.
  - LOCKED -> CONFIRM when a different pixel is hit (cnt=1).
  - Any state -> IDLE when en=0. In that cycle cnt, hit_seen and last are cleared.
- Write issue:
  - Exactly one write per entry into LOCKED, on the cycle after the entering frame_start.
  - Loads wr_row/wr_col=last, wr_data=~erase, sets wr_valid, and updates pos_row/pos_col.
  - Staying in LOCKED issues no repeat writes.
- Handshake:
  - wr_valid and wr_row/wr_col/wr_data stay stable until wr_valid&wr_ready. wr_valid drops the cycle after the transfer.
  - A new issue while wr_valid&~wr_ready is dropped and sets overflow. overflow is cleared only by rst.
  - Issue in the same cycle as an accepting transfer is legal: new data is loaded and wr_valid stays 1.
- en deassert mid-operation: a pending write still completes. pos_row/pos_col hold their values.
- pix_row/pix_col are ignored when d_valid=0.

Decomposition:
- Shared package/include (same style as st_state.v): state encodings IDLE/SEEK/CONFIRM/LOCKED, 3-bit coordinate width, PIX_ON=1/PIX_OFF=0.
- Sub-module: pen_delay_line (parameterised DLY shift register for {valid,row,col}). All other logic stays in pen_locator.

Test Plan:
- DLY=2, CONFIRM=2: probe (3,5) lit at cycle t, pen rising at t+2, in 2 consecutive frames -> after the 2nd frame_start, wr_valid=1, wr_row=3, wr_col=5, wr_data=1, pen_on=1. Exactly one write.
- Pen rising at t+1 instead of t+2 while (3,4) is lit at t+1 -> candidate is the pixel lit at t-1, not (3,4). Confirms the delay alignment.
- Hit (2,2) in frame 1, hit (2,3) in frame 2, hit (2,3) in frame 3 -> single write at (2,3) after frame 3. No write for (2,2).
- Locked on (1,1) with wr_ready=0, then pen moves to (6,6) and confirms -> first write held stable, (6,6) dropped, overflow=1. Raising wr_ready transfers (1,1).
- erase=1, confirm (0,7) -> wr_data=0. en dropped mid-CONFIRM -> state IDLE, no write, cnt=0.
- rst asserted while wr_valid=1 -> next cycle all outputs 0 and state IDLE.
